// File: rtl/csi_rx_vc_packet_handler_pkg.sv
// Shared constants for the CSI-2 RX virtual-channel packet handler:
// data types, packet header field layout and the handler state encoding.
package csi_rx_pkg;

  localparam logic [5:0] FS_DT_DEF    = 6'h00;
  localparam logic [5:0] FE_DT_DEF    = 6'h01;
  localparam logic [5:0] VIDEO_DT_DEF = 6'h2A;
  localparam logic [5:0] SHORT_DT_MAX = 6'h0F;

  localparam int HDR_DT_LSB = 0;
  localparam int HDR_DT_W   = 6;
  localparam int HDR_VC_LSB = 6;
  localparam int HDR_VC_W   = 2;
  localparam int HDR_WC_LSB = 8;
  localparam int HDR_WC_W   = 16;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    PAYLOAD   = 2'd1,
    SKIP      = 2'd2,
    DONE      = 2'd3
  } rx_state_e;

  function automatic logic is_short_dt(input logic [5:0] dt);
    return dt <= SHORT_DT_MAX;
  endfunction

endpackage

// File: rtl/csi_rx_vc_packet_handler_if.sv
// Word stream into the packet handler and the video payload stream out of it.
interface csi_rx_vc_packet_handler_if;

  // Both directions are valid-only streams without backpressure: a word is
  // transferred in every cycle its enable is high and must be taken then.
  logic [31:0] data;
  logic        data_enable;
  logic        data_frame;
  logic        lp_detect;

  logic [31:0] payload;
  logic        payload_enable;
  logic        payload_frame;
  logic [1:0]  payload_vc;

  modport master (
    output data, data_enable, data_frame, lp_detect,
    input  payload, payload_enable, payload_frame, payload_vc
  );

  modport slave (
    input  data, data_enable, data_frame, lp_detect,
    output payload, payload_enable, payload_frame, payload_vc
  );

endinterface

// File: rtl/csi_rx_vc_tracker.sv
// Per-virtual-channel frame/line status. Line counter exists only when
// CSI_RX_LINE_COUNT_EN is defined; otherwise line_count_o is tied to zero.
module csi_rx_vc_tracker (
  input  logic        clock,
  input  logic        areset_n,
  input  logic        fs_i,
  input  logic        fe_i,
  input  logic        line_start_i,
  input  logic        line_end_i,
  input  logic        line_count_inc_i,
  output logic        vsync_o,
  output logic        in_frame_o,
  output logic        in_line_o,
  output logic [15:0] line_count_o
);

  logic vsync_q, in_frame_q, in_line_q;

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      vsync_q    <= 1'b0;
      in_frame_q <= 1'b0;
      in_line_q  <= 1'b0;
    end else begin
      vsync_q <= fs_i;
      if (fs_i) begin
        in_frame_q <= 1'b1;
      end else if (fe_i) begin
        in_frame_q <= 1'b0;
      end
      if (fe_i || line_end_i) begin
        in_line_q <= 1'b0;
      end else if (line_start_i) begin
        in_line_q <= 1'b1;
      end
    end
  end

  assign vsync_o    = vsync_q;
  assign in_frame_o = in_frame_q;
  assign in_line_o  = in_line_q;

`ifdef CSI_RX_LINE_COUNT_EN
  logic [15:0] line_count_q;

  // A repeated frame start restarts line numbering for the new frame.
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      line_count_q <= 16'd0;
    end else if (fs_i && in_frame_q) begin
      line_count_q <= 16'd0;
    end else if (line_count_inc_i) begin
      line_count_q <= line_count_q + 16'd1;
    end
  end

  assign line_count_o = line_count_q;
`else
  logic unused_line_count_inc;
  assign unused_line_count_inc = line_count_inc_i;
  assign line_count_o = 16'd0;
`endif

endmodule

// File: rtl/csi_rx_vc_packet_handler.sv
// CSI-2 RX packet handler: decodes headers, forwards accepted video payload
// and tracks per-VC frame state. Optional line counters: CSI_RX_LINE_COUNT_EN.
module csi_rx_vc_packet_handler
  import csi_rx_pkg::*;
#(
  parameter int          NUM_VC   = 2,
  parameter logic [1:0]  VC_BASE  = 2'b00,
  parameter logic [5:0]  FS_DT    = FS_DT_DEF,
  parameter logic [5:0]  FE_DT    = FE_DT_DEF,
  parameter logic [5:0]  VIDEO_DT = VIDEO_DT_DEF,
  parameter logic [15:0] MAX_LEN  = 16'd8192
) (
  input  logic                   clock,
  input  logic                   areset_n,
  csi_rx_vc_packet_handler_if.slave rx,
  output logic                   sync_wait,
  output logic                   packet_done,
  output logic [NUM_VC-1:0]      vsync,
  output logic [NUM_VC-1:0]      in_frame,
  output logic [NUM_VC-1:0]      in_line,
  output logic [16*NUM_VC-1:0]   line_count,
  output rx_state_e              state_o
);

  rx_state_e   state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic [1:0]  pkt_idx_q, pkt_idx_d;
  logic        line_q, line_d;
  logic        count_q, count_d;
  logic [1:0]  payload_vc_q, payload_vc_d;
  logic [31:0] payload_q, payload_d;
  logic        payload_en_q, payload_frame_q, payload_frame_d;

  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc, hdr_idx, evt_idx;
  logic [15:0] hdr_wc;
  logic [2:0]  vc_ext, vc_lo, vc_hi;
  logic        vc_ok, word_out, abort;
  logic        fs_hit, fe_hit, start_hit, end_hit, cnt_hit;
  logic [NUM_VC-1:0] evt_sel, fs_vec, fe_vec, start_vec, end_vec, cnt_vec;

  assign hdr_dt  = rx.data[HDR_DT_LSB +: HDR_DT_W];
  assign hdr_vc  = rx.data[HDR_VC_LSB +: HDR_VC_W];
  assign hdr_wc  = rx.data[HDR_WC_LSB +: HDR_WC_W];
  assign hdr_idx = hdr_vc - VC_BASE;
  assign vc_ext  = {1'b0, hdr_vc};
  assign vc_lo   = {1'b0, VC_BASE};
  assign vc_hi   = vc_lo + 3'(NUM_VC);
  assign vc_ok   = (vc_ext >= vc_lo) && (vc_ext < vc_hi);
  assign abort   = rx.lp_detect || (cycle_cnt_q == MAX_LEN - 16'd1);

  // Framing comes from the header word count; data_frame is not needed.
  logic unused_data_frame;
  assign unused_data_frame = rx.data_frame;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    cycle_cnt_d  = cycle_cnt_q;
    pkt_idx_d    = pkt_idx_q;
    line_d       = line_q;
    count_d      = count_q;
    payload_vc_d = payload_vc_q;
    evt_idx      = pkt_idx_q;
    word_out     = 1'b0;
    fs_hit       = 1'b0;
    fe_hit       = 1'b0;
    start_hit    = 1'b0;
    end_hit      = 1'b0;
    cnt_hit      = 1'b0;
    case (state_q)
      WAIT_SYNC: begin
        if (rx.data_enable) begin
          evt_idx     = hdr_idx;
          pkt_idx_d   = hdr_idx;
          line_d      = 1'b0;
          count_d     = 1'b0;
          cycle_cnt_d = 16'd0;
          remaining_d = hdr_wc;
          if (is_short_dt(hdr_dt)) begin
            state_d = DONE;
            fs_hit  = vc_ok && (hdr_dt == FS_DT);
            fe_hit  = vc_ok && (hdr_dt == FE_DT);
          end else if (vc_ok && (hdr_dt == VIDEO_DT)) begin
            start_hit    = 1'b1;
            line_d       = 1'b1;
            count_d      = 1'b1;
            payload_vc_d = hdr_vc;
            state_d      = (hdr_wc == 16'd0) ? DONE : PAYLOAD;
          end else begin
            state_d = (hdr_wc == 16'd0) ? DONE : SKIP;
          end
        end
      end
      PAYLOAD, SKIP: begin
        cycle_cnt_d = cycle_cnt_q + 16'd1;
        // An abort wins over a word arriving in the same cycle.
        if (abort) begin
          state_d = DONE;
          count_d = 1'b0;
        end else if (rx.data_enable) begin
          word_out    = (state_q == PAYLOAD);
          remaining_d = (remaining_q > 16'(BYTES_PER_WORD)) ?
                        remaining_q - 16'(BYTES_PER_WORD) : 16'd0;
          if (remaining_q <= 16'(BYTES_PER_WORD)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        end_hit = line_q;
        cnt_hit = count_q;
        state_d = WAIT_SYNC;
      end
      default: state_d = WAIT_SYNC;
    endcase

    evt_sel   = NUM_VC'(1) << evt_idx;
    fs_vec    = {NUM_VC{fs_hit}}    & evt_sel;
    fe_vec    = {NUM_VC{fe_hit}}    & evt_sel;
    start_vec = {NUM_VC{start_hit}} & evt_sel;
    end_vec   = {NUM_VC{end_hit}}   & evt_sel;
    cnt_vec   = {NUM_VC{cnt_hit}}   & evt_sel;

    payload_d = word_out ? rx.data : payload_q;
    if (state_q != PAYLOAD) begin
      payload_frame_d = 1'b0;
    end else if (word_out) begin
      payload_frame_d = 1'b1;
    end else begin
      payload_frame_d = payload_frame_q;
    end
  end

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state_q         <= WAIT_SYNC;
      remaining_q     <= 16'd0;
      cycle_cnt_q     <= 16'd0;
      pkt_idx_q       <= 2'd0;
      line_q          <= 1'b0;
      count_q         <= 1'b0;
      payload_vc_q    <= 2'd0;
      payload_q       <= 32'd0;
      payload_en_q    <= 1'b0;
      payload_frame_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      cycle_cnt_q     <= cycle_cnt_d;
      pkt_idx_q       <= pkt_idx_d;
      line_q          <= line_d;
      count_q         <= count_d;
      payload_vc_q    <= payload_vc_d;
      payload_q       <= payload_d;
      payload_en_q    <= word_out;
      payload_frame_q <= payload_frame_d;
    end
  end

  assign sync_wait         = (state_q == WAIT_SYNC);
  assign packet_done       = (state_q == DONE);
  assign state_o           = state_q;
  assign rx.payload        = payload_q;
  assign rx.payload_enable = payload_en_q;
  assign rx.payload_frame  = payload_frame_q;
  assign rx.payload_vc     = payload_vc_q;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    csi_rx_vc_tracker u_tracker (
      .clock            (clock),
      .areset_n         (areset_n),
      .fs_i             (fs_vec[i]),
      .fe_i             (fe_vec[i]),
      .line_start_i     (start_vec[i]),
      .line_end_i       (end_vec[i]),
      .line_count_inc_i (cnt_vec[i]),
      .vsync_o          (vsync[i]),
      .in_frame_o       (in_frame[i]),
      .in_line_o        (in_line[i]),
      .line_count_o     (line_count[16*i +: 16])
    );
  end

endmodule

// File: tb/tb_csi_rx_vc_packet_handler.sv
// Randomized directed bench for csi_rx_vc_packet_handler against a packet-level model.
module tb_csi_rx_vc_packet_handler;
  import csi_rx_pkg::*;

  localparam int          NUM_VC   = 2;
  localparam int          VC_BASE  = 0;
  localparam int          MAX_LEN  = 8192;
  localparam logic [5:0]  FS       = 6'h00;
  localparam logic [5:0]  FE       = 6'h01;
  localparam logic [5:0]  VIDEO    = 6'h2A;

  // clock / reset
  logic clock = 1'b0;
  logic areset_n;
  always #5 clock = ~clock;

  csi_rx_vc_packet_handler_if ifc ();
  logic                 sync_wait, packet_done;
  logic [NUM_VC-1:0]    vsync, in_frame, in_line;
  logic [16*NUM_VC-1:0] line_count;
  rx_state_e            state_dbg;

  csi_rx_vc_packet_handler dut (
    .clock       (clock),
    .areset_n    (areset_n),
    .rx          (ifc),
    .sync_wait   (sync_wait),
    .packet_done (packet_done),
    .vsync       (vsync),
    .in_frame    (in_frame),
    .in_line     (in_line),
    .line_count  (line_count),
    .state_o     (state_dbg)
  );

  // scoreboard and model state
  logic [31:0] exp_q[$];
  int          exp_t[$];
  logic [31:0] obs_q[$];
  int          obs_t[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          done_cnt = 0, exp_done = 0, last_done_cyc = 0;
  int          frame_err = 0, vc_err = 0;
  int          vs_cnt[NUM_VC], exp_vs[NUM_VC];
  bit          exp_if[NUM_VC];
  logic [15:0] exp_lc[NUM_VC];
  logic [1:0]  cur_vc = 2'd0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (ifc.payload_enable === 1'b1) begin
      obs_q.push_back(ifc.payload);
      obs_t.push_back(cyc);
      if (ifc.payload_frame !== 1'b1) frame_err++;
      if (ifc.payload_vc !== cur_vc) vc_err++;
    end
    if (packet_done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    for (int i = 0; i < NUM_VC; i++) if (vsync[i] === 1'b1) vs_cnt[i]++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_word(input logic [31:0] w, input bit push);
    ifc.data        = w;
    ifc.data_enable = 1'b1;
    ifc.data_frame  = 1'b1;
    if (push) begin
      exp_q.push_back(w);
      exp_t.push_back(cyc + 1);
    end
    tick();
    ifc.data_enable = 1'b0;
  endtask

  task automatic check_all();
    logic [15:0] lc_exp;
    check("sync_wait", sync_wait, 1);
    check("packet_done_count", done_cnt, exp_done);
    check("payload_count", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      check("payload_data", obs_q.pop_front(), exp_q.pop_front());
      check("payload_latency", obs_t.pop_front(), exp_t.pop_front());
    end
    exp_q.delete(); obs_q.delete(); exp_t.delete(); obs_t.delete();
    check("payload_frame_err", frame_err, 0);
    check("payload_vc_err", vc_err, 0);
    for (int i = 0; i < NUM_VC; i++) begin
`ifdef CSI_RX_LINE_COUNT_EN
      lc_exp = exp_lc[i];
`else
      lc_exp = 16'd0;
`endif
      check($sformatf("in_frame[%0d]", i), in_frame[i], exp_if[i]);
      check($sformatf("in_line[%0d]", i), in_line[i], 0);
      check($sformatf("line_count[%0d]", i), line_count[16*i +: 16], lc_exp);
      check($sformatf("vsync_pulses[%0d]", i), vs_cnt[i], exp_vs[i]);
    end
  endtask

  // Sends one packet; abort_after >= 0 raises lp_detect after that many payload words.
  task automatic packet(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                        input logic [7:0] ecc, input int abort_after);
    bit acc, vid, aborted;
    int idx, nw;
    logic [31:0] w;
    acc = (int'(vc) >= VC_BASE) && (int'(vc) < VC_BASE + NUM_VC);
    idx = int'(vc) - VC_BASE;
    vid = acc && (dt == VIDEO);
    aborted = 1'b0;
    nw = 0;
    if (vid) cur_vc = vc;
    drive_word({ecc, wc, vc, dt}, 1'b0);
    if (dt <= 6'h0F) begin
      if (acc && dt == FS) begin
        if (exp_if[idx]) exp_lc[idx] = 16'd0;
        exp_if[idx] = 1'b1;
        exp_vs[idx]++;
      end else if (acc && dt == FE) begin
        exp_if[idx] = 1'b0;
      end
    end else begin
      nw = (int'(wc) + 3) / 4;
      if (vid) check("in_line_after_header", in_line[idx], 1);
    end
    for (int i = 0; i < nw; i++) begin
      if (i == abort_after) begin
        ifc.lp_detect = 1'b1;
        tick();
        ifc.lp_detect = 1'b0;
        aborted = 1'b1;
        break;
      end
      repeat ($urandom_range(0, 2)) tick();
      w = $urandom();
      drive_word(w, vid);
    end
    if (vid && !aborted) exp_lc[idx] = exp_lc[idx] + 16'd1;
    exp_done++;
    repeat (3) tick();
    ifc.data_frame = 1'b0;
    check_all();
  endtask

  initial begin
    logic [31:0] r;
    logic [5:0]  dts[5];
    int          h, elapsed, ab;
    dts = '{FS, FE, 6'h05, VIDEO, 6'h12};
    for (int i = 0; i < NUM_VC; i++) begin
      vs_cnt[i] = 0; exp_vs[i] = 0; exp_if[i] = 1'b0; exp_lc[i] = 16'd0;
    end
    areset_n = 1'b0;
    ifc.data = 32'd0; ifc.data_enable = 1'b0; ifc.data_frame = 1'b0; ifc.lp_detect = 1'b0;
    tick(); tick();
    check("reset_sync_wait", sync_wait, 1);
    check("reset_packet_done", packet_done, 0);
    check("reset_payload_enable", ifc.payload_enable, 0);
    check("reset_in_frame", in_frame, 0);
    check("reset_line_count", line_count, 0);
    areset_n = 1'b1;
    tick();

    packet(2'd0, FS, 16'd0, 8'h00, -1);
    packet(2'd0, VIDEO, 16'd16, 8'h5A, -1);
    packet(2'd3, VIDEO, 16'd16, 8'h11, -1);
    packet(2'd0, VIDEO, 16'd0, 8'h22, -1);
    packet(2'd0, VIDEO, 16'd7, 8'h33, -1);
    packet(2'd1, FE, 16'd0, 8'h44, -1);

    for (int k = 0; k < 12; k++) begin
      r = $urandom();
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      packet(2'($urandom_range(0, 3)), dts[$urandom_range(0, 4)], 16'($urandom_range(0, 23)), r[7:0], ab);
    end

    packet(2'd0, FS, 16'd0, 8'h01, -1);
    packet(2'd0, VIDEO, 16'd16, 8'h02, -1);
    packet(2'd0, FS, 16'd0, 8'h03, -1);
    packet(2'd0, VIDEO, 16'd16, 8'h04, -1);
    packet(2'd0, VIDEO, 16'd16, 8'h05, 2);

    // payload timeout with no further words
    cur_vc = 2'd0;
    h = cyc;
    drive_word({8'h06, 16'd8192, 2'd0, VIDEO}, 1'b0);
    check("timeout_in_line", in_line[0], 1);
    for (int k = 0; k < MAX_LEN + 20 && done_cnt == exp_done; k++) tick();
    elapsed = last_done_cyc - h;
    check("timeout_cycles", (elapsed >= MAX_LEN && elapsed <= MAX_LEN + 2), 1);
    exp_done++;
    repeat (3) tick();
    check_all();

    // reset in the middle of a video payload
    cur_vc = 2'd1;
    drive_word({8'h07, 16'd16, 2'd1, VIDEO}, 1'b0);
    r = $urandom(); drive_word(r, 1'b1);
    r = $urandom(); drive_word(r, 1'b1);
    @(negedge clock);
    #1;
    areset_n = 1'b0;
    #1;
    check("arst_sync_wait", sync_wait, 1);
    check("arst_packet_done", packet_done, 0);
    check("arst_payload_enable", ifc.payload_enable, 0);
    check("arst_payload_frame", ifc.payload_frame, 0);
    check("arst_payload", ifc.payload, 0);
    check("arst_payload_vc", ifc.payload_vc, 0);
    check("arst_vsync", vsync, 0);
    check("arst_in_frame", in_frame, 0);
    check("arst_in_line", in_line, 0);
    check("arst_line_count", line_count, 0);
    for (int i = 0; i < NUM_VC; i++) begin
      exp_if[i] = 1'b0; exp_lc[i] = 16'd0;
    end
    tick(); tick();
    areset_n = 1'b1;
    tick();
    check_all();
    packet(2'd1, FS, 16'd0, 8'h08, -1);
    packet(2'd1, VIDEO, 16'd12, 8'h09, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csi_rx_vc_packet_handler.md
CSI_RX_VC_PACKET_HANDLER -- requirements
Module: csi_rx_vc_packet_handler

Interface
REQ-001 Parameter NUM_VC, default 2: number of virtual channels tracked (1..4), VC_BASE..VC_BASE+NUM_VC-1.
REQ-002 Parameter VC_BASE, default 2'b00: lowest accepted virtual channel; VC_BASE+NUM_VC SHALL NOT exceed 4.
REQ-003 Parameters FS_DT 6'h00, FE_DT 6'h01, VIDEO_DT 6'h2A: frame start, frame end and video payload data types.
REQ-004 Parameter MAX_LEN, default 16'd8192: payload timeout in clock cycles.
REQ-005 clock  in  1  word clock; single clock domain.
REQ-006 areset_n  in  1  asynchronous, active-low reset.
REQ-007 data  in  32  combined word; byte0 = data[7:0].
REQ-008 data_enable  in  1  data valid this cycle.
REQ-009 data_frame  in  1  word belongs to a packet.
REQ-010 lp_detect  in  1  lane entered LP state.
REQ-011 sync_wait  out  1  high while waiting for a packet header.
REQ-012 packet_done  out  1  one-cycle pulse at end of every packet.
REQ-013 payload  out  32  video payload word.
REQ-014 payload_enable  out  1  payload valid.
REQ-015 payload_frame  out  1  high for the duration of an accepted video payload.
REQ-016 payload_vc  out  2  VC of the current payload.
REQ-017 vsync, in_frame, in_line  out  NUM_VC each  per-VC frame status, bit i = VC_BASE+i.
REQ-018 line_count  out  16*NUM_VC  per-VC completed-line counter.

Function
REQ-019 States: WAIT_SYNC, PAYLOAD, SKIP, DONE; reset state WAIT_SYNC.
REQ-020 WAIT_SYNC: sync_wait=1; on data_enable the word is decoded as a header: VC=data[7:6], DT=data[5:0], WC=data[23:8].
REQ-021 Short packet (DT<=6'h0F) -> DONE; FS_DT on accepted VC sets in_frame[i] and pulses vsync[i] one cycle; FE_DT clears in_frame[i] and in_line[i].
REQ-022 Long packet with DT==VIDEO_DT and accepted VC -> PAYLOAD; load remaining=WC, set in_line[i], payload_vc=VC; WC==0 -> DONE directly.
REQ-023 Long packet with other DT or non-accepted VC -> SKIP; bytes consumed identically, no payload output.
REQ-024 PAYLOAD/SKIP: each data_enable word subtracts 4 from remaining (saturating at 0); the word where remaining<=4 is the last, then -> DONE.
REQ-025 Payload latency: payload/payload_enable registered, one cycle after the data word; payload_frame high from the first payload word to the cycle after the last.
REQ-026 DONE: packet_done=1 for exactly one cycle, clear in_line[i], increment line_count[i] (wrap at 16'hFFFF->0) if the packet was video, -> WAIT_SYNC.
REQ-027 Abort: lp_detect high or cycle counter reaching MAX_LEN in PAYLOAD/SKIP -> DONE next cycle; abort takes priority over a simultaneous last word; aborted line not counted.
REQ-028 FS on a VC already in_frame: in_frame stays 1, vsync pulses, line_count[i] clears; FE without frame: no change.
REQ-029 Headers on non-accepted VCs leave all per-VC outputs unchanged.

Reset
REQ-030 areset_n low: state WAIT_SYNC, all outputs 0 except sync_wait=1, counters 0; effective immediately, mid-packet included.
REQ-031 After release, first data_enable word is treated as a header.

Configuration
REQ-032 Macro CSI_RX_LINE_COUNT_EN defined: line_count behaves per REQ-026/REQ-028.
REQ-033 Macro undefined: line_count port present, driven constant 0, no counter flops.

Structure
REQ-034 Package csi_rx_pkg holds DT constants, header field positions/widths, short/long DT threshold and the state enumeration.
REQ-035 Sub-module csi_rx_vc_tracker, one instance per VC, owns vsync/in_frame/in_line/line_count for that VC.

Verification
REQ-036 FS header 32'h0000_0000 on VC0 -> vsync[0] one-cycle pulse, in_frame[0]=1, packet_done one pulse.
REQ-037 Header VC0 DT 2A WC 16 + 4 words -> 4 payload_enable cycles with one-cycle latency, packet_done, line_count[0]=1.
REQ-038 Video header on VC3 with NUM_VC=2 -> 4 words skipped, payload_enable never high, packet_done pulse.
REQ-039 lp_detect after 2 of 4 payload words -> DONE next cycle, in_line[0]=0, line_count unchanged.
REQ-040 WC=8192 and no further data_enable -> timeout after MAX_LEN cycles, packet_done pulse, back to sync_wait=1.
REQ-041 areset_n low mid-payload -> all outputs reset same cycle, sync_wait=1.
